// File: rtl/cms_sample_streamer.sv
// Sample source for the complex mean-square unit: buffers (y, y_hat) pairs and streams them on request.
// Optional watchdog enabled by defining CMS_STREAMER_TIMEOUT_EN.
module cms_sample_streamer #(
   parameter int unsigned ADDR_W         = 7,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [31:0]        wr_y,
   input  logic [31:0]        wr_y_hat,
   input  logic               run,
   input  logic [2:0]         log2n,
   output logic               busy,
   output logic [63:0]        result,
   output logic               result_valid,
   output logic               timeout,
   output logic               cms_start,
   output logic [2:0]         cms_log2n,
   output logic [31:0]        cms_y,
   output logic [31:0]        cms_y_hat,
   input  logic               cms_next_number,
   input  logic               cms_done,
   input  logic [63:0]        cms_result
);

   typedef enum logic [1:0] {IDLE, LOAD, STREAM, WAIT_DONE} state_t;

   state_t            state, state_next;
   logic [31:0]       mem_y     [2**ADDR_W];
   logic [31:0]       mem_y_hat [2**ADDR_W];
   logic [ADDR_W-1:0] ptr;
   logic [7:0]        sent;
   logic [7:0]        sent_inc;
   logic [7:0]        n_target;
   logic              accept;
   logic              wd_fire;

   if (ADDR_W < 7 || TIMEOUT_CYCLES == 0) begin : g_param_check
      $error("cms_sample_streamer: ADDR_W must be >= 7 and TIMEOUT_CYCLES nonzero");
   end

   assign accept   = (state == STREAM) && cms_next_number;
   assign sent_inc = sent + 8'd1;
   assign n_target = 8'd1 << cms_log2n;

   always_ff @(posedge clk) begin
      if (wr_en && !busy) begin
         mem_y[wr_addr]     <= wr_y;
         mem_y_hat[wr_addr] <= wr_y_hat;
      end
   end

`ifdef CMS_STREAMER_TIMEOUT_EN
   logic [31:0] wd_cnt;
   logic        timeout_q;

   // Request/done take priority over expiry on the same edge.
   assign wd_fire = (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) &&
                    (((state == STREAM) && !cms_next_number) ||
                     ((state == WAIT_DONE) && !cms_done));
   assign timeout = timeout_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == IDLE && run) begin
            timeout_q <= 1'b0;
         end else if (wd_fire) begin
            timeout_q <= 1'b1;
         end
         if (state == LOAD || accept) begin
            wd_cnt <= '0;
         end else if (state == STREAM || state == WAIT_DONE) begin
            wd_cnt <= wd_cnt + 32'd1;
         end
      end
   end
`else
   assign wd_fire = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (run) state_next = LOAD;
         LOAD:      state_next = STREAM;
         STREAM: begin
            if (accept && sent_inc == n_target) state_next = WAIT_DONE;
            else if (wd_fire)                   state_next = IDLE;
         end
         WAIT_DONE: if (cms_done || wd_fire) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy         <= 1'b0;
         cms_start    <= 1'b0;
         cms_log2n    <= '0;
         cms_y        <= '0;
         cms_y_hat    <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         ptr          <= '0;
         sent         <= '0;
      end else begin
         busy <= (state_next != IDLE);
         case (state)
            IDLE: begin
               if (run) begin
                  cms_log2n    <= log2n;
                  result_valid <= 1'b0;
                  sent         <= '0;
                  ptr          <= '0;
               end
            end
            LOAD: begin
               cms_y     <= mem_y[ptr];
               cms_y_hat <= mem_y_hat[ptr];
               ptr       <= ptr + ADDR_W'(1);
               cms_start <= 1'b1;
            end
            STREAM: begin
               cms_start <= 1'b0;
               if (accept) begin
                  sent      <= sent_inc;
                  cms_y     <= mem_y[ptr];
                  cms_y_hat <= mem_y_hat[ptr];
                  ptr       <= ptr + ADDR_W'(1);
               end
            end
            WAIT_DONE: begin
               if (cms_done) begin
                  result       <= cms_result;
                  result_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/cms_sample_streamer.md
# cms_sample_streamer

Sample source for the complex mean-square unit: it holds up to 2^ADDR_W (y, y_hat) pairs loaded by a host and, on `run`, starts the mean-square unit. It answers each `next_number` request with the next stored pair and captures the final 64-bit result when the unit reports done. It is the producer end of the `next_number` / `done` sample protocol and sits between the host register interface and the mean-square unit.

## Interface
- `ADDR_W`, 7, buffer address width; depth = 2^ADDR_W; must be ≥ 7 so log2n = 7 fits.
- `TIMEOUT_CYCLES`, 1024, watchdog limit in cycles; used only with `CMS_STREAMER_TIMEOUT_EN`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `wr_en` in 1: host buffer write strobe.
- `wr_addr` in ADDR_W: host write address.
- `wr_y` in 32: y word to store.
- `wr_y_hat` in 32: y_hat word to store.
- `run` in 1: start a streaming run.
- `log2n` in 3: run length is N = 1 << log2n.
- `busy` out 1: run in progress.
- `result` out 64: captured mean-square result.
- `result_valid` out 1: `result` holds this run's value.
- `timeout` out 1: last run was aborted by the watchdog.
- `cms_start` out 1: start pulse to the mean-square unit.
- `cms_log2n` out 3: run length to the unit.
- `cms_y` out 32: sample to the unit.
- `cms_y_hat` out 32: reference sample to the unit.
- `cms_next_number` in 1: unit request; the pair on `cms_y`/`cms_y_hat` is consumed at this edge.
- `cms_done` in 1: unit done (level, stale-high from the previous run until the unit re-inits).
- `cms_result` in 64: unit result.

## Operation
- Buffer: two 32-bit × 2^ADDR_W arrays, written when `wr_en` is high and `busy` is 0. A write while busy is dropped. The buffer is not cleared by reset.
- States:
  - IDLE → LOAD when `run` is high. On this edge: latch `log2n` into `cms_log2n`, clear `result_valid` and `timeout`, clear `sent`.
  - LOAD (1 cycle): `cms_y`/`cms_y_hat` ← entry 0, `ptr` ← 1, `cms_start` ← 1. → STREAM.
  - STREAM: `cms_start` ← 0.
    - On an edge with `cms_next_number` = 1: `sent` ← `sent` + 1, outputs ← entry[`ptr`], `ptr` ← `ptr` + 1. The address wraps modulo the depth.
    - When the incremented `sent` equals N → WAIT_DONE.
  - WAIT_DONE: on `cms_done` = 1: `result` ← `cms_result`, `result_valid` ← 1. → IDLE.
- `cms_done` is ignored outside WAIT_DONE; this masks the stale done level from the previous run.
- `cms_next_number` is ignored in IDLE, LOAD and WAIT_DONE.
- `run` is ignored while busy.
- `busy` = 1 in LOAD, STREAM and WAIT_DONE.
- Sample words pass through unmodified; there is no arithmetic on data.

## Timing
- Reset values: `busy` 0, `cms_start` 0, `cms_log2n` 0, `cms_y` 0, `cms_y_hat` 0, `result` 0, `result_valid` 0, `timeout` 0. State is IDLE.
- All outputs are registered. Entry k is stable on `cms_y` for the whole cycle in which the k-th `cms_next_number` is high.
- `cms_start` is high for exactly 1 cycle, 2 cycles after the `run` edge.
- `busy` rises 1 cycle after `run` is sampled high.
- `busy` falls and `result_valid` rises on the same edge, the first edge with `cms_done` = 1 in WAIT_DONE.
- `result` and `result_valid` hold until the next accepted `run`.
- Back-to-back `cms_next_number` cycles are honoured; one entry advances per high cycle.
- A reset mid-run returns to IDLE immediately and drops the run with no result.

## Configuration
- `CMS_STREAMER_TIMEOUT_EN` defined:
  - A cycle counter runs in STREAM and WAIT_DONE. It clears on entry to STREAM, on every accepted request, and on entry to WAIT_DONE.
  - When the counter reaches TIMEOUT_CYCLES: → IDLE, `timeout` ← 1, `result_valid` stays 0.
- Undefined: no counter, `timeout` is tied to 0, and the block waits indefinitely.

## Test plan
- Load entries 0..3 with y = i+1, y_hat = 0x10+i. Run with log2n = 2 against a scripted consumer that requests with 5-cycle gaps and then asserts done with `cms_result` = 64'h0000_0001_0000_0002 → consumer sees pairs (1,0x10),(2,0x11),(3,0x12),(4,0x13) in order; `result` = 64'h0000_0001_0000_0002; `result_valid` = 1; `busy` = 0.
- Consumer holds `cms_done` = 1 from the previous run until after the first request (log2n = 0) → no capture before the single handoff; capture occurs only in WAIT_DONE.
- `wr_en` to address 0 with y = 0xDEAD during a run, then re-run → the data is unchanged from the pre-run value.
- `run` asserted while busy, plus `cms_next_number` pulses after N handoffs → no restart, no extra pointer advance; the run completes normally.
- `reset` pulsed while in STREAM after 3 of 8 handoffs → all outputs at reset values the same cycle; a subsequent run restarts from entry 0.
- With `CMS_STREAMER_TIMEOUT_EN` and TIMEOUT_CYCLES = 16, the consumer never asserts done → exactly 16 cycles after WAIT_DONE entry: `timeout` = 1, `busy` = 0, `result_valid` = 0.
